bus_arbiter4: RTL and testbench
===============================

Name: bus_arbiter4

Overview:
- Round-robin arbiter that shares one 4:1 address/data mux between four requesters (fetch, load/store, DMA, debug).
- Drives the mux 2-bit select and a one-hot grant back to requesters.
- Enforces a maximum tenure per grant with a timeout.
- All outputs registered; sits between requester FSMs and the bus mux in the CPU datapath.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one owner may hold the bus; 0 disables timeout.
- CNT_WIDTH, 5, hold-counter width; must satisfy 2^CNT_WIDTH > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  4  request per requester; bit i = requester i; level-held until served.
- gnt  output  4  one-hot grant, or all-zero when no owner.
- select  output  2  mux select = index of current or last owner.
- bus_valid  output  1  high while any gnt bit is high.
- timeout  output  1  one-cycle pulse when a tenure is force-ended by MAX_HOLD.

Behaviour:
- Reset (async, active-high):
  - gnt=0, select=0, bus_valid=0, timeout=0, hold_cnt=0.
  - last_winner=3, so requester 0 has first priority.
  - State IDLE.
- Priority: search order starts at (last_winner+1) mod 4, ascending, wraps modulo 4.
- IDLE:
  - If req!=0 at a clock edge, the winner is registered. Next cycle: gnt[w]=1, select=w, bus_valid=1, last_winner=w, hold_cnt=1, state OWNED.
  - Request-to-grant latency is 1 cycle.
  - If req==0, stay IDLE; select holds its last value.
- OWNED (owner o):
  - Hold: req[o]=1 and (MAX_HOLD==0 or hold_cnt<MAX_HOLD).
    - Keep grant; hold_cnt increments.
    - hold_cnt saturates at all-ones when MAX_HOLD==0; no wrap.
  - Release: req[o]=0.
    - Arbitrate among current req, which excludes o since req[o]=0.
    - If another requester wins, switch directly next cycle: no idle bubble, hold_cnt=1.
    - If none, go to IDLE: gnt=0, bus_valid=0.
  - Timeout: req[o]=1 and hold_cnt==MAX_HOLD (MAX_HOLD!=0).
    - timeout=1 for exactly the next cycle.
    - Rearbitrate with o lowest priority (pointer starts at o+1).
    - If another req is present, it wins next cycle.
    - If only o requests, o is re-granted with hold_cnt=1. gnt[o] stays high continuously, but timeout still pulses.
- Invariants:
  - gnt is always one-hot or zero.
  - select always equals the index of the high gnt bit.
  - A grant change never leaves two bits high in any cycle.
  - With all four requesting continuously, each gets the bus within 3*MAX_HOLD+3 cycles: no starvation.
- Simultaneous events: release and new requests in the same cycle resolve per the Release rule. New requests arriving while OWNED are ignored until release or timeout.
- Reset mid-tenure clears the grant immediately, without waiting for a clock edge. After reset deassertion, behaviour restarts from IDLE with requester 0 first.
- Requesters must not drop req before receiving gnt. If they do, the arbiter takes no special action; a grant to a now-idle requester is released on the following cycle.

Test Plan:
- Reset priority:
  - Stimulus: reset, then req=4'b1111 from cycle 1.
  - Required: cycle 2 gnt=0001, select=0, bus_valid=1. Assert reset async mid-tenure: gnt=0 and bus_valid=0 before the next clk edge.
- Round-robin rotation:
  - Stimulus: req=1111. Each owner drops its req after 2 cycles of grant, then re-raises 1 cycle later.
  - Required: grant order 0,1,2,3,0 with no idle cycle between owners.
- Timeout:
  - Stimulus: MAX_HOLD=4; req=0011 held constantly.
  - Required: gnt=0001 for 4 cycles; timeout pulses 1 cycle; gnt=0010 for 4 cycles; timeout pulses; back to 0001.
- Sole-owner timeout:
  - Stimulus: MAX_HOLD=4, req=0100 held.
  - Required: gnt=0100 continuously, select=2, timeout pulse every 4 cycles, bus_valid never drops.
- Release to idle:
  - Stimulus: req=1000 for 3 cycles, then 0000.
  - Required: gnt=1000 one cycle after req rises; gnt=0 and bus_valid=0 one cycle after req falls; select stays 3.
  - Follow-up: a subsequent req=1001 grants 0 first, because the pointer is at 0 after winner 3.
- Timeout disabled:
  - Stimulus: MAX_HOLD=0, req=0011 held 100 cycles.
  - Required: gnt=0001 throughout, timeout never asserted, hold_cnt saturates without wrap.

Source files
------------

// File: rtl/bus_arbiter4.sv
// Four-way round-robin bus arbiter with registered one-hot grant, mux select and
// per-tenure hold limit (MAX_HOLD cycles, 0 = unlimited).
module bus_arbiter4 #(
  parameter int unsigned MAX_HOLD  = 16,
  parameter int unsigned CNT_WIDTH = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] select,
  output logic       bus_valid,
  output logic       timeout
);

  localparam logic [CNT_WIDTH-1:0] MaxHoldCnt = CNT_WIDTH'(MAX_HOLD);
  localparam logic [CNT_WIDTH-1:0] CntOne     = CNT_WIDTH'(1);

  typedef enum logic {StIdle, StOwned} state_t;

  state_t               state_q, state_d;
  logic [3:0]           gnt_q, gnt_d;
  logic [1:0]           sel_q, sel_d;
  logic [1:0]           last_q, last_d;
  logic [CNT_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
  logic                 tmo_q, tmo_d;
  logic                 valid_q, valid_d;

  logic       found;
  logic [1:0] win;
  logic [1:0] cand;
  logic       hold_ok;
  logic       grant_new;

  // Search starts one past the last winner; the owner itself is checked last,
  // which covers both the release case (its req is low) and sole-owner timeout.
  always_comb begin
    found = 1'b0;
    win   = last_q;
    cand  = last_q;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign hold_ok = req[last_q] && ((MAX_HOLD == 0) || (hold_cnt_q < MaxHoldCnt));

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    tmo_d      = 1'b0;
    grant_new  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (found) grant_new = 1'b1;
      end
      StOwned: begin
        if (hold_ok) begin
          if (hold_cnt_q != '1) hold_cnt_d = hold_cnt_q + 1'b1;
        end else begin
          // Owner still requesting but not allowed to hold: tenure was force-ended.
          tmo_d = req[last_q];
          if (found) begin
            grant_new = 1'b1;
          end else begin
            state_d = StIdle;
            gnt_d   = 4'b0000;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (grant_new) begin
      state_d    = StOwned;
      gnt_d      = 4'b0001 << win;
      sel_d      = win;
      last_d     = win;
      hold_cnt_d = CntOne;
    end

    valid_d = |gnt_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      gnt_q      <= 4'b0000;
      sel_q      <= 2'd0;
      last_q     <= 2'd3;
      hold_cnt_q <= '0;
      tmo_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      tmo_q      <= tmo_d;
      valid_q    <= valid_d;
    end
  end

  assign gnt       = gnt_q;
  assign select    = sel_q;
  assign bus_valid = valid_q;
  assign timeout   = tmo_q;

endmodule

// File: tb/tb_bus_arbiter4.sv
// Directed bench for bus_arbiter4: three instances cover MAX_HOLD = 16, 4 and 0.
module tb_bus_arbiter4;

  logic       clk;
  logic       reset;
  logic [3:0] req;

  logic [3:0] gnt_a, gnt_b, gnt_c;
  logic [1:0] sel_a, sel_b, sel_c;
  logic       bv_a, bv_b, bv_c;
  logic       tmo_a, tmo_b, tmo_c;

  int tests;
  int fails;

  bus_arbiter4 dut16 (
    .clk(clk), .reset(reset), .req(req),
    .gnt(gnt_a), .select(sel_a), .bus_valid(bv_a), .timeout(tmo_a)
  );

  bus_arbiter4 #(.MAX_HOLD(4), .CNT_WIDTH(3)) dut4 (
    .clk(clk), .reset(reset), .req(req),
    .gnt(gnt_b), .select(sel_b), .bus_valid(bv_b), .timeout(tmo_b)
  );

  bus_arbiter4 #(.MAX_HOLD(0), .CNT_WIDTH(3)) dut0 (
    .clk(clk), .reset(reset), .req(req),
    .gnt(gnt_c), .select(sel_c), .bus_valid(bv_c), .timeout(tmo_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [1:0] o;
    logic [3:0] eg;
    tests = 0;
    fails = 0;
    reset = 1'b1;
    req   = 4'b0000;

    // Reset state and requester 0 first priority
    #3;
    check("rst_gnt", 8'(gnt_a), 8'h0);
    check("rst_sel", 8'(sel_a), 8'h0);
    check("rst_bv", 8'(bv_a), 8'h0);
    check("rst_tmo", 8'(tmo_a), 8'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    req   = 4'b1111;
    step();
    check("prio_gnt", 8'(gnt_a), 8'h1);
    check("prio_sel", 8'(sel_a), 8'h0);
    check("prio_bv", 8'(bv_a), 8'h1);
    step();
    #2;
    reset = 1'b1;
    #1;
    check("async_gnt", 8'(gnt_a), 8'h0);
    check("async_bv", 8'(bv_a), 8'h0);

    // Round robin: each owner holds 2 cycles, drops, re-raises 1 cycle later
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      o  = 2'(k % 4);
      eg = 4'b0001 << o;
      step();
      check("rr_gnt1", 8'(gnt_a), 8'(eg));
      check("rr_sel1", 8'(sel_a), 8'(o));
      check("rr_bv1", 8'(bv_a), 8'h1);
      req = 4'b1111;
      step();
      check("rr_gnt2", 8'(gnt_a), 8'(eg));
      req = 4'b1111 & ~eg;
    end

    // Timeout with two requesters (MAX_HOLD=4)
    do_reset();
    req = 4'b0011;
    for (int i = 0; i < 12; i++) begin
      step();
      eg = ((i / 4) % 2 == 0) ? 4'b0001 : 4'b0010;
      check("to_gnt", 8'(gnt_b), 8'(eg));
      check("to_tmo", 8'(tmo_b), (i > 0 && i % 4 == 0) ? 8'h1 : 8'h0);
    end

    // Sole-owner timeout: grant stays, timeout still pulses
    do_reset();
    req = 4'b0100;
    for (int i = 0; i < 12; i++) begin
      step();
      check("solo_gnt", 8'(gnt_b), 8'h4);
      check("solo_sel", 8'(sel_b), 8'h2);
      check("solo_bv", 8'(bv_b), 8'h1);
      check("solo_tmo", 8'(tmo_b), (i > 0 && i % 4 == 0) ? 8'h1 : 8'h0);
    end

    // Release to idle, then pointer wraps to requester 0
    do_reset();
    req = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rel_gnt", 8'(gnt_a), 8'h8);
      check("rel_sel", 8'(sel_a), 8'h3);
    end
    req = 4'b0000;
    step();
    check("idle_gnt", 8'(gnt_a), 8'h0);
    check("idle_bv", 8'(bv_a), 8'h0);
    check("idle_sel", 8'(sel_a), 8'h3);
    step();
    check("idle_sel2", 8'(sel_a), 8'h3);
    req = 4'b1001;
    step();
    check("wrap_gnt", 8'(gnt_a), 8'h1);
    check("wrap_sel", 8'(sel_a), 8'h0);

    // Timeout disabled: owner keeps bus, counter saturates
    do_reset();
    req = 4'b0011;
    for (int i = 0; i < 100; i++) begin
      step();
      check("nto_gnt", 8'(gnt_c), 8'h1);
      check("nto_tmo", 8'(tmo_c), 8'h0);
    end
    check("nto_sat", 8'(dut0.hold_cnt_q), 8'h7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
